// File: rtl/sie_defs_pkg.sv
// Shared definitions for the full-speed USB serial interface engine:
// bus line-state encoding and the oversampling ratio used by the receive DPLL.
package sie_defs_pkg;

    localparam int FS_SAMPLES_PER_BIT = 4;
    localparam int PHASE_W            = $clog2(FS_SAMPLES_PER_BIT);

    // Bit centre sits half a bit period after the edge that resynchronises the DPLL.
    localparam logic [PHASE_W-1:0] STROBE_PHASE = PHASE_W'(FS_SAMPLES_PER_BIT / 2);

    // Encoded as {D+, D-} so the pair can be cast directly.
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } usb_line_state_e;

    function automatic usb_line_state_e line_state(input logic p, input logic n);
        return usb_line_state_e'({p, n});
    endfunction

endpackage

// File: rtl/usb_rx_deserializer.sv
// Strobe-enabled LSB-first shift register with a modulo-8 bit counter.
// A byte is complete on the shift that wraps the counter from 7 to 0.
module usb_rx_deserializer
    import sie_defs_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       strobe_i,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] data_o,
    output logic       full_o
);

    logic [7:0] data_q, data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       full_q, full_d;

    always_comb begin
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        full_d    = full_q;
        if (strobe_i) begin
            // Any strobe that does not complete a byte drops the full flag,
            // so it stays high for exactly one bit period.
            full_d = 1'b0;
            if (clear_i) begin
                bit_cnt_d = 3'd0;
            end else if (en_i) begin
                data_d    = {bit_i, data_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                full_d    = (bit_cnt_q == 3'd7);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q    <= 8'h00;
            bit_cnt_q <= 3'd0;
            full_q    <= 1'b0;
        end else begin
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            full_q    <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/usb_rx_frontend.sv
// Full-speed USB receive front end: pad synchroniser, 4x-oversampling DPLL,
// EOP and bus-reset detection, and the byte deserializer fed by the SIE.
module usb_rx_frontend
    import sie_defs_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int EOP_MIN_SE0      = 4,
    parameter int RESET_SE0_CYCLES = 120
) (
    input  logic       clk48,
    input  logic       RST,
    input  logic       dataInP,
    input  logic       dataInN,
    output logic       syncP,
    output logic       syncN,
    output logic       readCLK12,
    output logic       bitStrobe,
    input  logic       eopClear,
    output logic       eop,
    input  logic       ACK_USB_RST,
    output logic       usbReset,
    input  logic       shiftClear,
    input  logic       shiftEN,
    input  logic       shiftIN,
    output logic [7:0] dataOut,
    output logic       bufferFull
);

    localparam int                  SE0_CNT_W = $clog2(RESET_SE0_CYCLES + 1);
    localparam logic [SE0_CNT_W-1:0] SE0_MAX  = SE0_CNT_W'(RESET_SE0_CYCLES);
    localparam logic [SE0_CNT_W-1:0] EOP_MIN  = SE0_CNT_W'(EOP_MIN_SE0);

    logic [SYNC_STAGES-1:0] sync_p_q, sync_p_d;
    logic [SYNC_STAGES-1:0] sync_n_q, sync_n_d;

    always_comb begin
        sync_p_d    = sync_p_q;
        sync_n_d    = sync_n_q;
        sync_p_d[0] = dataInP;
        sync_n_d[0] = dataInN;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_p_d[i] = sync_p_q[i-1];
            sync_n_d[i] = sync_n_q[i-1];
        end
    end

    assign syncP = sync_p_q[SYNC_STAGES-1];
    assign syncN = sync_n_q[SYNC_STAGES-1];

    usb_line_state_e line_cur;
    usb_line_state_e line_prev_q;
    logic            line_edge;
    logic            line_se0;
    logic            line_j;

    assign line_cur  = line_state(syncP, syncN);
    assign line_edge = (line_cur != line_prev_q);
    assign line_se0  = (line_cur == LS_SE0);
    assign line_j    = (line_cur == LS_J);

    // The edge cycle is treated as phase 0, so the strobe lands two cycles later.
    logic [PHASE_W-1:0] phase_q, phase_d, phase_eff;

    assign phase_eff = line_edge ? '0 : phase_q;
    assign phase_d   = phase_eff + PHASE_W'(1);
    assign bitStrobe = (phase_eff == STROBE_PHASE);
    assign readCLK12 = phase_eff[PHASE_W-1];

    logic [SE0_CNT_W-1:0] se0_cnt_q, se0_cnt_d;
    logic                 eop_q, eop_d;
    logic                 usb_rst_q, usb_rst_d;
    logic                 rearm_q, rearm_d;
    logic                 eop_hit;
    logic                 rst_hit;

    always_comb begin
        se0_cnt_d = '0;
        if (line_se0) begin
            se0_cnt_d = (se0_cnt_q == SE0_MAX) ? SE0_MAX : se0_cnt_q + SE0_CNT_W'(1);
        end
    end

    assign eop_hit = line_j && (se0_cnt_q >= EOP_MIN);
    assign eop_d   = eopClear ? 1'b0 : (eop_q | eop_hit);

    // The counter stays saturated through a long SE0; the rearm bit stops an
    // acknowledged reset from re-flagging until the line leaves SE0.
    assign rst_hit   = rearm_q && line_se0 && (se0_cnt_d == SE0_MAX);
    assign usb_rst_d = ACK_USB_RST ? 1'b0 : (usb_rst_q | rst_hit);

    always_comb begin
        rearm_d = rearm_q;
        if (!line_se0) begin
            rearm_d = 1'b1;
        end else if (ACK_USB_RST) begin
            rearm_d = 1'b0;
        end
    end

    always_ff @(posedge clk48) begin
        if (RST) begin
            sync_p_q    <= '0;
            sync_n_q    <= '0;
            line_prev_q <= LS_SE0;
            phase_q     <= '0;
            se0_cnt_q   <= '0;
            eop_q       <= 1'b0;
            usb_rst_q   <= 1'b0;
            rearm_q     <= 1'b1;
        end else begin
            sync_p_q    <= sync_p_d;
            sync_n_q    <= sync_n_d;
            line_prev_q <= line_cur;
            phase_q     <= phase_d;
            se0_cnt_q   <= se0_cnt_d;
            eop_q       <= eop_d;
            usb_rst_q   <= usb_rst_d;
            rearm_q     <= rearm_d;
        end
    end

    assign eop      = eop_q;
    assign usbReset = usb_rst_q;

    usb_rx_deserializer u_deser (
        .clk_i    (clk48),
        .rst_i    (RST),
        .strobe_i (bitStrobe),
        .clear_i  (shiftClear),
        .en_i     (shiftEN),
        .bit_i    (shiftIN),
        .data_o   (dataOut),
        .full_o   (bufferFull)
    );

endmodule

// File: tb/tb_usb_rx_frontend.sv
// Directed bench for usb_rx_frontend: reset, DPLL lock and jitter, deserializer,
// EOP detection, bus reset with acknowledge, and priority corner cases.
module tb_usb_rx_frontend;

    logic       clk48 = 1'b0;
    logic       RST = 1'b1;
    logic       dataInP = 1'b1;
    logic       dataInN = 1'b0;
    logic       syncP, syncN, readCLK12, bitStrobe;
    logic       eopClear = 1'b0;
    logic       eop;
    logic       ACK_USB_RST = 1'b0;
    logic       usbReset;
    logic       shiftClear = 1'b0;
    logic       shiftEN = 1'b0;
    logic       shiftIN = 1'b0;
    logic [7:0] dataOut;
    logic       bufferFull;

    int total = 0;
    int bad   = 0;

    usb_rx_frontend dut (
        .clk48       (clk48),
        .RST         (RST),
        .dataInP     (dataInP),
        .dataInN     (dataInN),
        .syncP       (syncP),
        .syncN       (syncN),
        .readCLK12   (readCLK12),
        .bitStrobe   (bitStrobe),
        .eopClear    (eopClear),
        .eop         (eop),
        .ACK_USB_RST (ACK_USB_RST),
        .usbReset    (usbReset),
        .shiftClear  (shiftClear),
        .shiftEN     (shiftEN),
        .shiftIN     (shiftIN),
        .dataOut     (dataOut),
        .bufferFull  (bufferFull)
    );

    always #10 clk48 = ~clk48;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic pads(input logic p, input logic n);
        dataInP = p;
        dataInN = n;
    endtask

    // Wait (bounded) for a strobe cycle, present the deserializer inputs for it.
    task automatic strobe_shift(input logic clr, input logic en, input logic b);
        int n = 0;
        while (bitStrobe !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        total++;
        if (bitStrobe !== 1'b1) begin
            bad++;
            $display("FAIL strobe_wait: got %b required 1 within 8 cycles", bitStrobe);
        end
        shiftClear = clr;
        shiftEN    = en;
        shiftIN    = b;
        tick();
        shiftClear = 1'b0;
        shiftEN    = 1'b0;
        shiftIN    = 1'b0;
    endtask

    task automatic test_reset();
        pads(1'b1, 1'b0);
        RST = 1'b1;
        tick();
        tick();
        total++;
        if ({syncP, syncN, readCLK12, bitStrobe, eop, usbReset, bufferFull} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {syncP, syncN, readCLK12, bitStrobe, eop, usbReset, bufferFull});
        end
        total++;
        if (dataOut !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got %h required 00", dataOut);
        end
        RST = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            total++;
            if (bitStrobe !== ((i % 4) == 0)) begin
                bad++;
                $display("FAIL reset_strobe[%0d]: got %b required %b", i, bitStrobe, (i % 4) == 0);
            end
            if (i >= 2) begin
                total++;
                if (readCLK12 !== ((i % 4) == 0 || (i % 4) == 1)) begin
                    bad++;
                    $display("FAIL reset_clk12[%0d]: got %b", i, readCLK12);
                end
            end
            if (i == 2) begin
                total++;
                if (syncP !== 1'b1 || syncN !== 1'b0) begin
                    bad++;
                    $display("FAIL sync_lag: got %b%b required 10", syncP, syncN);
                end
            end
        end
    endtask

    task automatic test_dpll_lock();
        int lens [8] = '{4, 4, 4, 5, 4, 3, 4, 4};
        int prev_len = 0;
        tick();
        for (int s = 0; s < 8; s++) begin
            if (s % 2 == 0) pads(1'b0, 1'b1);
            else            pads(1'b1, 1'b0);
            for (int i = 1; i <= lens[s]; i++) begin
                tick();
                if (i >= 2 || s > 0) begin
                    logic exp_s;
                    exp_s = (i == 1) ? (prev_len == 3) : (i == 4);
                    total++;
                    if (bitStrobe !== exp_s) begin
                        bad++;
                        $display("FAIL dpll_strobe[s%0d i%0d]: got %b required %b",
                                 s, i, bitStrobe, exp_s);
                    end
                end
            end
            prev_len = lens[s];
        end
    endtask

    task automatic test_deserialize();
        logic [7:0] pat = 8'hA5;
        strobe_shift(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            strobe_shift(1'b0, 1'b1, pat[k]);
            if (k == 3) begin
                total++;
                if (dataOut !== 8'h50) begin
                    bad++;
                    $display("FAIL deser_half: got %h required 50", dataOut);
                end
            end
            if (k == 6) begin
                total++;
                if (bufferFull !== 1'b0) begin
                    bad++;
                    $display("FAIL deser_early_full: got %b required 0", bufferFull);
                end
            end
        end
        total++;
        if (dataOut !== 8'hA5 || bufferFull !== 1'b1) begin
            bad++;
            $display("FAIL deser_byte: got %h/%b required a5/1", dataOut, bufferFull);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (bufferFull !== (c < 3)) begin
                bad++;
                $display("FAIL deser_full_width[%0d]: got %b required %b", c, bufferFull, c < 3);
            end
        end
    endtask

    task automatic test_skip_bit();
        logic [7:0] pat = 8'hA5;
        strobe_shift(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) strobe_shift(1'b0, 1'b1, pat[k]);
        strobe_shift(1'b0, 1'b0, 1'b1);
        total++;
        if (dataOut !== 8'h5A || bufferFull !== 1'b0) begin
            bad++;
            $display("FAIL skip_hold: got %h/%b required 5a/0", dataOut, bufferFull);
        end
        for (int k = 4; k < 8; k++) begin
            strobe_shift(1'b0, 1'b1, pat[k]);
            if (k == 6) begin
                total++;
                if (bufferFull !== 1'b0) begin
                    bad++;
                    $display("FAIL skip_early_full: got %b required 0", bufferFull);
                end
            end
        end
        total++;
        if (dataOut !== 8'hA5 || bufferFull !== 1'b1) begin
            bad++;
            $display("FAIL skip_byte: got %h/%b required a5/1", dataOut, bufferFull);
        end
    endtask

    task automatic test_priority_shift();
        logic [7:0] pat = 8'h3C;
        strobe_shift(1'b1, 1'b0, 1'b0);
        total++;
        if (bufferFull !== 1'b0) begin
            bad++;
            $display("FAIL clear_full: got %b required 0", bufferFull);
        end
        for (int k = 0; k < 3; k++) strobe_shift(1'b0, 1'b1, 1'b1);
        strobe_shift(1'b1, 1'b1, 1'b1);
        total++;
        if (dataOut !== 8'hF4 || bufferFull !== 1'b0) begin
            bad++;
            $display("FAIL clear_wins: got %h/%b required f4/0", dataOut, bufferFull);
        end
        for (int k = 0; k < 8; k++) begin
            strobe_shift(1'b0, 1'b1, pat[k]);
            if (k == 6) begin
                total++;
                if (bufferFull !== 1'b0) begin
                    bad++;
                    $display("FAIL clear_cnt_early: got %b required 0", bufferFull);
                end
            end
        end
        total++;
        if (dataOut !== 8'h3C || bufferFull !== 1'b1) begin
            bad++;
            $display("FAIL clear_cnt_byte: got %h/%b required 3c/1", dataOut, bufferFull);
        end
    endtask

    task automatic test_eop();
        total++;
        if (eop !== 1'b0) begin
            bad++;
            $display("FAIL eop_idle: got %b required 0", eop);
        end
        pads(1'b0, 1'b0);
        repeat (8) tick();
        pads(1'b1, 1'b0);
        tick();
        tick();
        total++;
        if (eop !== 1'b0) begin
            bad++;
            $display("FAIL eop_latency: got %b required 0", eop);
        end
        tick();
        total++;
        if (eop !== 1'b1) begin
            bad++;
            $display("FAIL eop_set: got %b required 1", eop);
        end
        repeat (5) tick();
        total++;
        if (eop !== 1'b1) begin
            bad++;
            $display("FAIL eop_sticky: got %b required 1", eop);
        end
        eopClear = 1'b1;
        tick();
        eopClear = 1'b0;
        tick();
        tick();
        total++;
        if (eop !== 1'b0) begin
            bad++;
            $display("FAIL eop_clear: got %b required 0", eop);
        end
        // Three SE0 samples are too short.
        pads(1'b0, 1'b0);
        repeat (3) tick();
        pads(1'b1, 1'b0);
        repeat (6) tick();
        total++;
        if (eop !== 1'b0) begin
            bad++;
            $display("FAIL eop_short: got %b required 0", eop);
        end
        // Exactly the minimum run qualifies.
        pads(1'b0, 1'b0);
        repeat (4) tick();
        pads(1'b1, 1'b0);
        repeat (3) tick();
        total++;
        if (eop !== 1'b1) begin
            bad++;
            $display("FAIL eop_min: got %b required 1", eop);
        end
        eopClear = 1'b1;
        tick();
        eopClear = 1'b0;
        // A long SE0 ending in K is discarded.
        pads(1'b0, 1'b0);
        repeat (8) tick();
        pads(1'b0, 1'b1);
        repeat (4) tick();
        pads(1'b1, 1'b0);
        repeat (4) tick();
        total++;
        if (eop !== 1'b0) begin
            bad++;
            $display("FAIL eop_k_end: got %b required 0", eop);
        end
        // A qualifying J while eopClear is held is ignored.
        eopClear = 1'b1;
        pads(1'b0, 1'b0);
        repeat (8) tick();
        pads(1'b1, 1'b0);
        repeat (4) tick();
        eopClear = 1'b0;
        repeat (2) tick();
        total++;
        if (eop !== 1'b0) begin
            bad++;
            $display("FAIL eop_held_clear: got %b required 0", eop);
        end
    endtask

    task automatic test_bus_reset();
        pads(1'b0, 1'b0);
        for (int i = 1; i <= 122; i++) begin
            tick();
            if (i == 1 || i == 121) begin
                total++;
                if (usbReset !== 1'b0) begin
                    bad++;
                    $display("FAIL busrst_early[%0d]: got %b required 0", i, usbReset);
                end
            end
        end
        total++;
        if (usbReset !== 1'b1) begin
            bad++;
            $display("FAIL busrst_set: got %b required 1", usbReset);
        end
        tick();
        total++;
        if (usbReset !== 1'b1) begin
            bad++;
            $display("FAIL busrst_sticky: got %b required 1", usbReset);
        end
        ACK_USB_RST = 1'b1;
        tick();
        ACK_USB_RST = 1'b0;
        total++;
        if (usbReset !== 1'b0) begin
            bad++;
            $display("FAIL busrst_ack: got %b required 0", usbReset);
        end
        repeat (20) tick();
        total++;
        if (usbReset !== 1'b0) begin
            bad++;
            $display("FAIL busrst_no_reflag: got %b required 0", usbReset);
        end
        pads(1'b1, 1'b0);
        repeat (4) tick();
        pads(1'b0, 1'b0);
        for (int i = 1; i <= 122; i++) begin
            tick();
            if (i == 121) begin
                total++;
                if (usbReset !== 1'b0) begin
                    bad++;
                    $display("FAIL busrst_rearm_early: got %b required 0", usbReset);
                end
            end
        end
        total++;
        if (usbReset !== 1'b1) begin
            bad++;
            $display("FAIL busrst_rearm_set: got %b required 1", usbReset);
        end
        ACK_USB_RST = 1'b1;
        tick();
        ACK_USB_RST = 1'b0;
        // Acknowledge coincident with a fresh set: acknowledge wins.
        pads(1'b1, 1'b0);
        repeat (4) tick();
        pads(1'b0, 1'b0);
        repeat (121) tick();
        ACK_USB_RST = 1'b1;
        tick();
        ACK_USB_RST = 1'b0;
        total++;
        if (usbReset !== 1'b0) begin
            bad++;
            $display("FAIL busrst_ack_wins: got %b required 0", usbReset);
        end
        repeat (10) tick();
        total++;
        if (usbReset !== 1'b0) begin
            bad++;
            $display("FAIL busrst_ack_wins_hold: got %b required 0", usbReset);
        end
        pads(1'b1, 1'b0);
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_dpll_lock();
        test_deserialize();
        test_skip_bit();
        test_priority_shift();
        test_eop();
        test_bus_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_frontend.md
Name: usb_rx_frontend

Overview:
Full-speed USB receive front end on the 48 MHz domain.
- Synchronizes the D+/D- pair.
- Recovers the 12 Mbit/s bit timing with a 4x-oversampling digital PLL.
- Detects EOP and bus reset (long SE0).
- Deserializes the unstuffed bit stream into bytes.
- Sits between the pads and the SIE receive state machine; NRZI decoding and bit unstuffing are external, fed back in via shiftEN/shiftIN.

Parameters:
SYNC_STAGES, 2, synchronizer flops on dataInP/dataInN.
EOP_MIN_SE0, 4, minimum consecutive SE0 samples (clk48) preceding J for a valid EOP.
RESET_SE0_CYCLES, 120, consecutive SE0 samples (2.5 us at 48 MHz) that flag bus reset.

Ports:
clk48  in  1  sole clock, 48 MHz.
RST  in  1  reset; synchronous, active-high.
dataInP  in  1  raw D+ pad.
dataInN  in  1  raw D- pad.
syncP  out  1  synchronized D+.
syncN  out  1  synchronized D-.
readCLK12  out  1  recovered bit clock, rising edge at bit centre.
bitStrobe  out  1  one-cycle pulse at bit centre, same instant as the readCLK12 rise.
eopClear  in  1  clears/holds eop low.
eop  out  1  sticky EOP flag.
ACK_USB_RST  in  1  acknowledges usbReset.
usbReset  out  1  sticky bus-reset flag.
shiftClear  in  1  restart byte alignment; sampled on bitStrobe.
shiftEN  in  1  current bit valid (not stuffed); sampled on bitStrobe.
shiftIN  in  1  decoded bit; sampled on bitStrobe.
dataOut  out  8  deserializer contents.
bufferFull  out  1  8 bits collected.

Behaviour:
- Reset values (after RST is sampled high): all outputs 0, phase=0, bit counter=0, SE0 counters=0, synchronizer flops=0.
- Synchronizer: SYNC_STAGES flops per line; syncP/syncN lag the pads by SYNC_STAGES cycles. All logic below uses synced values.
- Line states:
  - SE0 = (0,0).
  - J = (P=1,N=0).
  - K = (0,1).
- DPLL:
  - 2-bit phase counter increments every cycle and wraps 3->0.
  - On a cycle where (syncP,syncN) differs from the previous cycle, the next phase is 1 (the edge cycle counts as phase 0).
  - bitStrobe=1 when phase==2.
  - readCLK12 = phase[1], giving a 50% duty clock.
  - The counter free-runs between edges. RST realigns phase to 0.
- EOP detection:
  - The SE0 run counter counts consecutive SE0 samples and saturates at RESET_SE0_CYCLES.
  - When a J sample follows a run of at least EOP_MIN_SE0 samples, eop is set next cycle.
  - eop stays set until eopClear or RST.
  - While eopClear=1, eop is forced 0 and a qualifying J is ignored. The run counter keeps counting regardless of eopClear.
  - A run shorter than EOP_MIN_SE0, or ending in K or SE1, is discarded.
- Bus reset:
  - When the run counter reaches RESET_SE0_CYCLES, usbReset is set and stays set until ACK_USB_RST or RST.
  - After ACK_USB_RST, no re-flag occurs until the line has left SE0 at least one sample (rearm bit).
  - ACK_USB_RST asserted in the same cycle as a new set: ACK wins.
- Deserializer (acts only on bitStrobe cycles):
  - shiftClear=1: bit counter:=0, no shift, bufferFull:=0. Clear wins over shiftEN.
  - Else shiftEN=1: dataOut := {shiftIN, dataOut[7:1]}, so LSB-first arrival ends in bit0 after 8 shifts. Counter increments mod 8.
  - On the shift that brings the counter from 7 to 0, bufferFull:=1; otherwise bufferFull:=0 on every strobe.
  - bufferFull is therefore high for exactly one bit period (4 clk48 cycles). shiftEN=0 also clears it on that strobe.
  - dataOut holds its value when not shifting, so dataOut[7:4] always holds the 4 most recent accepted bits (used for sync detect).

Decomposition:
- sie_defs_pkg gains USB line-state enum (SE0,J,K,SE1) and constant FS_SAMPLES_PER_BIT=4.
- One natural sub-module: usb_rx_deserializer (the shift register plus bit counter, strobe-enabled).
- DPLL and SE0 detection stay inline.

Test Plan:
- Reset: assert RST 2 cycles with pads idle J -> all outputs 0, then bitStrobe every 4 cycles.
- DPLL lock: K/J alternating each 4 cycles with pad edges at arbitrary phase -> bitStrobe occurs exactly 2 cycles after each synced edge. Jitter of +/-1 cycle on one edge -> strobe realigns accordingly.
- Deserialize: shiftClear on one strobe, then shiftIN bits 1,0,1,0,0,1,0,1 with shiftEN=1 -> dataOut=8'hA5, bufferFull high for exactly 4 cycles. A shiftEN=0 strobe mid-byte is skipped (byte still 8'hA5 after 9 strobes).
- EOP: SE0 8 cycles then J -> eop=1 one cycle after J sampled, stays 1. eopClear -> 0. SE0 3 cycles then J -> eop stays 0.
- Bus reset: SE0 120 cycles -> usbReset=1 at count 120. ACK while still SE0 -> 0 and stays 0. J then SE0 120 cycles -> 1 again.
- Priority: shiftClear and shiftEN on same strobe -> no shift, counter 0. ACK_USB_RST coincident with set -> usbReset 0.
